// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the instruction-memory request handshake,
// a single-entry hold buffer and the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_src,
    input  logic        if_flush,
    input  logic [31:0] jr_target,
    input  logic        stall_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        fetch_state
);

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic        hold_valid;
    logic [31:0] redir_q;
    logic        req_en;
    logic        transfer;
    logic        redirect;
    logic [31:0] target;

    // Handshake: imem_req is the valid, imem_ack the ready. A word moves only in a
    // cycle with both high; once raised, imem_req and imem_addr stay put until then.
    assign imem_req    = req_en & ~hold_valid;
    assign imem_addr   = pc;
    assign transfer    = imem_req & imem_ack;
    assign pc_plus4    = pc + 32'd4;
    assign redirect    = if_flush & id_valid & ~stall_id;
    assign fetch_state = state;

    always_comb begin
        target = id_pc4;
        case (pc_src)
            2'b00:   target = id_pc4;
            2'b01:   target = {id_pc4[31:28], id_instr[25:0], 2'b00};
            2'b10:   target = id_pc4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
            default: target = jr_target;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            id_instr   <= 32'd0;
            id_pc4     <= 32'd0;
            id_valid   <= 1'b0;
            hold_instr <= 32'd0;
            hold_pc4   <= 32'd0;
            hold_valid <= 1'b0;
            redir_q    <= 32'd0;
            req_en     <= 1'b0;
        end else begin
            req_en <= 1'b1;
            case (state)
                FETCH: begin
                    if (redirect) begin
                        id_valid   <= 1'b0;
                        id_instr   <= 32'd0;
                        hold_valid <= 1'b0;
                        if (transfer || !imem_req) begin
                            pc <= target;
                        end else begin
                            // The pending fetch must complete before the PC may move.
                            redir_q <= target;
                            state   <= DROP;
                        end
                    end else if (transfer && !stall_id) begin
                        id_instr <= imem_rdata;
                        id_pc4   <= pc_plus4;
                        id_valid <= 1'b1;
                        pc       <= pc_plus4;
                    end else if (transfer) begin
                        hold_instr <= imem_rdata;
                        hold_pc4   <= pc_plus4;
                        hold_valid <= 1'b1;
                        pc         <= pc_plus4;
                    end else if (hold_valid && !stall_id) begin
                        id_instr   <= hold_instr;
                        id_pc4     <= hold_pc4;
                        id_valid   <= 1'b1;
                        hold_valid <= 1'b0;
                    end else if (!stall_id) begin
                        id_valid <= 1'b0;
                        id_instr <= 32'd0;
                    end
                end
                DROP: begin
                    if (transfer) begin
                        pc    <= redir_q;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic        if_flush;
    logic [31:0] jr_target;
    logic        stall_id;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        fetch_state;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_src     (pc_src),
        .if_flush   (if_flush),
        .jr_target  (jr_target),
        .stall_id   (stall_id),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_instr   (id_instr),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid),
        .fetch_state(fetch_state)
    );

    // ---------------- instruction memory ----------------
    logic [31:0] mem_ovr [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // ---------------- reference model ----------------
    // exp_q holds fetched words (instr, pc+4) waiting to enter ID; never more than one.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    logic        m_req_en;
    logic        m_iv;
    logic [31:0] m_ii;
    logic [31:0] m_ip4;
    logic        m_drop;
    logic [31:0] m_drop_tgt;

    function automatic logic m_req();
        return m_req_en && (exp_q.size() == 0);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0000_0100;
        m_req_en = 1'b0;
        m_iv = 1'b0;
        m_ii = 32'd0;
        m_ip4 = 32'd0;
        m_drop = 1'b0;
        m_drop_tgt = 32'd0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] redirect_target(input logic [1:0] src, input logic [31:0] jt);
        int off;
        case (src)
            2'b00:   return m_ip4;
            2'b01:   return (m_ip4 & 32'hF000_0000) | ((m_ii & 32'h03FF_FFFF) * 4);
            2'b10: begin
                off = int'($signed(m_ii[15:0])) * 4;
                return m_ip4 + 32'(off);
            end
            default: return jt;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic f, input logic [1:0] src,
                              input logic [31:0] jt, input logic s, input logic ack,
                              input logic [31:0] rdata);
        logic req;
        logic xfer;
        logic [31:0] tgt;
        logic [63:0] w;
        if (!rst) begin
            model_reset();
            return;
        end
        req  = m_req();
        xfer = req && ack;
        if (m_drop) begin
            if (xfer) begin
                m_pc = m_drop_tgt;
                m_drop = 1'b0;
            end
        end else if (f && m_iv && !s) begin
            tgt = redirect_target(src, jt);
            m_iv = 1'b0;
            m_ii = 32'd0;
            exp_q.delete();
            if (xfer || !req) m_pc = tgt;
            else begin
                m_drop = 1'b1;
                m_drop_tgt = tgt;
            end
        end else if (xfer && !s) begin
            m_ii = rdata; m_ip4 = m_pc + 32'd4; m_iv = 1'b1;
            m_pc = m_pc + 32'd4;
        end else if (xfer) begin
            exp_q.push_back({rdata, m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
        end else if (exp_q.size() != 0 && !s) begin
            w = exp_q.pop_front();
            m_ii = w[63:32]; m_ip4 = w[31:0]; m_iv = 1'b1;
        end else if (!s) begin
            m_iv = 1'b0;
            m_ii = 32'd0;
        end
        m_req_en = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic rst, input logic f, input logic [1:0] src,
                       input logic [31:0] jt, input logic s, input logic ack);
        @(negedge clk);
        rst_n      = rst;
        if_flush   = f;
        pc_src     = src;
        jr_target  = jt;
        stall_id   = s;
        imem_ack   = ack;
        imem_rdata = mem_word(m_pc);
        #1;
        check("imem_req",  32'(imem_req),    32'(m_req()));
        check("imem_addr", imem_addr,        m_pc);
        check("id_valid",  32'(id_valid),    32'(m_iv));
        check("id_instr",  id_instr,         m_ii);
        check("id_pc4",    id_pc4,           m_ip4);
        check("state",     32'(fetch_state), 32'(m_drop));
        model_step(rst, f, src, jt, s, ack, imem_rdata);
        if (exp_q.size() > 1) check("hold_depth", 32'(exp_q.size()), 32'd1);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; if_flush = 1'b0; pc_src = 2'b00; jr_target = 32'd0;
        stall_id = 1'b0; imem_ack = 1'b1; imem_rdata = 32'd0;
        mem_ovr[32'h0000_0104] = 32'h1000_0003;
        mem_ovr[32'h2000_000C] = 32'h0800_0040;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset with ack held high
        repeat (3) cyc(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);

        // Straight-line fetch
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("sl_addr0", imem_addr, 32'h0000_0100);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("sl_pc4_0", id_pc4, 32'h0000_0104);
        check("sl_addr1", imem_addr, 32'h0000_0104);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("sl_pc4_1", id_pc4, 32'h0000_0108);
        check("beq_instr", id_instr, 32'h1000_0003);

        // Taken beq
        cyc(1'b1, 1'b1, 2'b10, 32'd0, 1'b0, 1'b1);
        after_edge(); check("beq_addr", imem_addr, 32'h0000_0114);
        check("beq_bubble", 32'(id_valid), 32'd0);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("beq_resume", 32'(id_valid), 32'd1);
        check("beq_pc4", id_pc4, 32'h0000_0118);

        // jr to the j instruction, then j
        cyc(1'b1, 1'b1, 2'b11, 32'h2000_000C, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("j_instr", id_instr, 32'h0800_0040);
        check("j_pc4", id_pc4, 32'h2000_0010);
        cyc(1'b1, 1'b1, 2'b01, 32'd0, 1'b0, 1'b1);
        after_edge(); check("j_addr", imem_addr, 32'h2000_0100);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'b11, 32'hDEAD_BEE0, 1'b0, 1'b1);
        after_edge(); check("jr_addr", imem_addr, 32'hDEAD_BEE0);

        // Redirect while a fetch waits three cycles
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'b11, 32'h0000_0400, 1'b0, 1'b0);
        after_edge(); check("drop_state", 32'(fetch_state), 32'd1);
        check("drop_addr", imem_addr, 32'hDEAD_BEE4);
        repeat (2) cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
        after_edge(); check("drop_hold_addr", imem_addr, 32'hDEAD_BEE4);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("drop_tgt", imem_addr, 32'h0000_0400);
        check("drop_novalid", 32'(id_valid), 32'd0);
        check("drop_exit", 32'(fetch_state), 32'd0);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("drop_next_pc4", id_pc4, 32'h0000_0404);

        // Stall with ack for four cycles, flush ignored during the stall
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 2'b11, 32'h0000_0800, 1'b1, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 1'b1);
        after_edge(); check("stall_req", 32'(imem_req), 32'd0);
        check("stall_pc4", id_pc4, 32'h0000_0404);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("release_pc4", id_pc4, 32'h0000_0408);
        check("release_req", 32'(imem_req), 32'd1);
        check("release_addr", imem_addr, 32'h0000_0408);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("release_next", id_pc4, 32'h0000_040C);

        // PC wrap
        cyc(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFC, 1'b0, 1'b1);
        after_edge(); check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
        after_edge(); check("wrap_addr1", imem_addr, 32'h0000_0000);
        check("wrap_pc4", id_pc4, 32'h0000_0000);

        // Randomized traffic, including occasional mid-transfer resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 4) == 0),
                2'($urandom_range(0, 3)),
                $urandom,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
